otbn_edn_responder: RTL and testbench

OTBN_EDN_RESPONDER -- requirements
Module: otbn_edn_responder

---
 rtl/otbn_pkg.sv | 18 +
 rtl/otbn_edn_responder.sv | 77 +++++++
 tb/tb_otbn_edn_responder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/otbn_pkg.sv
// OTBN shared definitions: EDN bus width and the EDN responder FSM states.
// Imported by otbn_edn_responder.
package otbn_pkg;

  parameter int EdnDataWidth = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    ACK  = 2'd3
  } otbn_edn_resp_state_e;

  function automatic int edn_beats(int src_w);
    return EdnDataWidth / src_w;
  endfunction

endpackage

// File: rtl/otbn_edn_responder.sv
// EDN responder: packs SrcWidth entropy words into one EdnDataWidth ack.
// OTBN_EDN_RESP_PREFETCH_EN: refill speculatively after reset and each ack.
module otbn_edn_responder
  import otbn_pkg::*;
#(
  parameter int SrcWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    edn_req_i,
  output logic                    edn_ack_o,
  output logic [EdnDataWidth-1:0] edn_data_o,
  input  logic                    src_valid_i,
  output logic                    src_ready_o,
  input  logic [SrcWidth-1:0]     src_data_i,
  output logic                    busy_o
);

  localparam int Beats = edn_beats(SrcWidth);
  localparam int CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

`ifdef OTBN_EDN_RESP_PREFETCH_EN
  localparam otbn_edn_resp_state_e ResetSt  = FILL;
  localparam otbn_edn_resp_state_e AfterAck = FILL;
`else
  localparam otbn_edn_resp_state_e ResetSt  = IDLE;
  localparam otbn_edn_resp_state_e AfterAck = IDLE;
`endif

  otbn_edn_resp_state_e    state;
  logic [CntW-1:0]         cnt;
  logic [EdnDataWidth-1:0] buffer;
  logic                    take;

  assign src_ready_o = (state == FILL);
  assign busy_o      = (state == FILL);
  assign edn_ack_o   = (state == ACK);
  assign edn_data_o  = edn_ack_o ? buffer : '0;
  assign take        = src_valid_i & src_ready_o;

  // The last beat goes straight to ACK if the consumer is already waiting.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= ResetSt;
      cnt    <= '0;
      buffer <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (edn_req_i) state <= FILL;
        end
        FILL: begin
          if (take) begin
            buffer[cnt*SrcWidth +: SrcWidth] <= src_data_i;
            if (cnt == LastBeat) begin
              cnt   <= '0;
              state <= edn_req_i ? ACK : FULL;
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
        end
        FULL: begin
          if (edn_req_i) state <= ACK;
        end
        ACK: begin
          state  <= AfterAck;
          cnt    <= '0;
          buffer <= '0;
        end
        default: state <= ResetSt;
      endcase
    end
  end

endmodule

// File: tb/tb_otbn_edn_responder.sv
// Randomized bench for otbn_edn_responder with an in-order word scoreboard.
// Build with OTBN_EDN_RESP_PREFETCH_EN to exercise the prefetch variant.
module tb_otbn_edn_responder;

  localparam int W  = 256;
  localparam int SW = 32;

  typedef enum int {SrcOff, SrcAlw, SrcTog, SrcRnd} src_mode_e;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          edn_req = 1'b0;
  logic          edn_ack;
  logic [W-1:0]  edn_data;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [SW-1:0] src_data = '0;
  logic          busy;

  src_mode_e     src_mode = SrcOff;
  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            ack_cnt = 0;
  int            ack_cyc = 0;
  int            hs_cnt = 0;
  int            hs_at_ack = 0;
  bit            got_ack = 1'b0;
  bit            took = 1'b0;
  logic [SW-1:0] q[$];
  logic [W-1:0]  last_data = '0;

  always #5 clk = ~clk;

  otbn_edn_responder #(.SrcWidth(SW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .edn_req_i  (edn_req),
    .edn_ack_o  (edn_ack),
    .edn_data_o (edn_data),
    .src_valid_i(src_valid),
    .src_ready_o(src_ready),
    .src_data_i (src_data),
    .busy_o     (busy)
  );

  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] seq(logic [SW-1:0] base);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / SW; i++) r[i*SW +: SW] = base + SW'(i);
    return r;
  endfunction

  // Every ack must carry the next eight accepted words, first word lowest.
  task automatic monitor();
    logic [W-1:0] exp;
    if (!rst_ni) begin
      q.delete();
      took = 1'b0;
    end else begin
      if (edn_ack) begin
        exp = '0;
        for (int i = 0; i < W / SW; i++)
          if (q.size() > 0) exp[i*SW +: SW] = q.pop_front();
        check("ack_data", edn_data, exp);
        ack_cnt++;
        got_ack   = 1'b1;
        ack_cyc   = cyc;
        hs_at_ack = hs_cnt;
        last_data = edn_data;
      end else begin
        check("data_zero", edn_data, '0);
      end
      took = src_valid && src_ready;
      if (took) begin
        q.push_back(src_data);
        hs_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (took) src_data = (src_mode == SrcRnd) ? $urandom : src_data + 1;
    case (src_mode)
      SrcAlw:  src_valid = 1'b1;
      SrcTog:  src_valid = ~src_valid;
      SrcRnd:  src_valid = 1'($urandom_range(0, 1));
      default: src_valid = 1'b0;
    endcase
  endtask

  task automatic src_cfg(src_mode_e mode, logic [SW-1:0] base);
    src_mode  = mode;
    src_data  = base;
    src_valid = (mode != SrcOff);
    hs_cnt    = 0;
  endtask

  task automatic wait_ack(int max, output int lat);
    int start;
    int n;
    start   = cyc;
    got_ack = 1'b0;
    n       = 0;
    while (!got_ack && n < max) begin
      tick();
      n++;
    end
    if (!got_ack) check("ack_timeout", W'(0), W'(1));
    lat = ack_cyc - start;
  endtask

  task automatic do_reset();
    edn_req = 1'b0;
    src_cfg(SrcOff, '0);
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni  = 1'b1;
    ack_cnt = 0;
    check("rst_ack", W'(edn_ack), W'(0));
    check("rst_data", edn_data, '0);
`ifdef OTBN_EDN_RESP_PREFETCH_EN
    check("rst_ready", W'(src_ready), W'(1));
    check("rst_busy", W'(busy), W'(1));
`else
    check("rst_ready", W'(src_ready), W'(0));
    check("rst_busy", W'(busy), W'(0));
`endif
  endtask

  initial begin
    int lat;
    int n;
    logic [SW-1:0] words[32];
    logic [SW-1:0] base;

`ifdef OTBN_EDN_RESP_PREFETCH_EN
    // Speculative fill, then two requests served from the full buffer
    do_reset();
    src_cfg(SrcAlw, 32'd1);
    repeat (20) tick();
    edn_req = 1'b1;
    wait_ack(50, lat);
    check("pf_lat1", W'(lat), W'(1));
    check("pf_data1", last_data, seq(32'd1));
    edn_req = 1'b0;
    repeat (12) tick();
    check("pf_full_busy", W'(busy), W'(0));
    edn_req = 1'b1;
    wait_ack(50, lat);
    check("pf_lat2", W'(lat), W'(1));
    check("pf_data2", last_data, seq(32'd9));
    edn_req = 1'b0;
`else
    // Basic latency and packing
    do_reset();
    src_cfg(SrcAlw, 32'd1);
    edn_req = 1'b1;
    wait_ack(50, lat);
    check("basic_lat", W'(lat), W'(9));
    check("basic_data", last_data,
      256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    check("basic_beats", W'(hs_at_ack), W'(8));
    edn_req = 1'b0;
    repeat (4) tick();
    check("basic_one_ack", W'(ack_cnt), W'(1));

    // Toggling source valid
    do_reset();
    src_cfg(SrcTog, 32'd1);
    edn_req = 1'b1;
    wait_ack(60, lat);
    check("tog_beats", W'(hs_at_ack), W'(8));
    check("tog_data", last_data, seq(32'd1));
    edn_req = 1'b0;
    repeat (3) tick();

    // Request withdrawn mid-fill: buffer held in FULL
    do_reset();
    src_cfg(SrcAlw, 32'h100);
    edn_req = 1'b1;
    n = 0;
    while (hs_cnt < 3 && n < 50) begin
      tick();
      n++;
    end
    edn_req = 1'b0;
    repeat (10) tick();
    check("drop_no_ack", W'(ack_cnt), W'(0));
    check("drop_beats", W'(hs_cnt), W'(8));
    check("drop_full_busy", W'(busy), W'(0));
    edn_req = 1'b1;
    wait_ack(50, lat);
    check("drop_lat", W'(lat), W'(1));
    check("drop_data", last_data, seq(32'h100));
    edn_req = 1'b0;
    repeat (3) tick();

    // Reset after beat 5 discards partial words
    do_reset();
    src_cfg(SrcAlw, 32'h200);
    edn_req = 1'b1;
    n = 0;
    while (hs_cnt < 5 && n < 50) begin
      tick();
      n++;
    end
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_no_ack", W'(ack_cnt), W'(0));
    src_cfg(SrcAlw, 32'h300);
    wait_ack(50, lat);
    check("mid_rst_lat", W'(lat), W'(9));
    check("mid_rst_data", last_data, seq(32'h300));
    edn_req = 1'b0;
    repeat (3) tick();
`endif

    // Back-to-back requests: 32 words in order, none lost or repeated
    do_reset();
    src_cfg(SrcAlw, 32'h1000);
    for (int k = 0; k < 4; k++) begin
      edn_req = 1'b1;
      wait_ack(50, lat);
      for (int i = 0; i < 8; i++) words[k*8 + i] = last_data[i*SW +: SW];
    end
    edn_req = 1'b0;
    check("b2b_acks", W'(ack_cnt), W'(4));
    for (int i = 0; i < 32; i++)
      check("b2b_word", W'(words[i]), W'(32'h1000 + i));

    // Random source data, random valid, random request gaps
    do_reset();
    base = $urandom;
    src_cfg(SrcRnd, base);
    for (int k = 0; k < 25; k++) begin
      edn_req = 1'b0;
      repeat ($urandom_range(0, 6)) tick();
      edn_req = 1'b1;
      wait_ack(300, lat);
    end
    edn_req = 1'b0;
    repeat (4) tick();
    check("rnd_acks", W'(ack_cnt), W'(25));
`ifndef OTBN_EDN_RESP_PREFETCH_EN
    check("rnd_leftover", W'(q.size()), W'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
